ahbl_req_master: RTL and testbench

AHBL_REQ_MASTER -- requirements
Module: ahbl_req_master

---
 rtl/ahbl_req_master.sv | 203 ++++++++++++++++++++
 tb/tb_ahbl_req_master.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahbl_req_master.sv
// ahbl_req_master
// Converts a simple valid/ready request stream into single NONSEQ transfers
// on an AHB-Lite master port. There are two pipeline stages, the address
// phase (APH) and the data phase (DPH), so zero-wait transfers run one per
// cycle. Each accepted request gets exactly one response, and responses
// come back in request order.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake
//   req_addr/req_write/req_size   request address, direction, HSIZE (0..2)
//   req_wdata                     write data, already byte-lane aligned
//   rsp_valid/rsp_rdata/rsp_err   one-cycle response pulse per request
//   bus_fault                     sticky; set when a data phase times out
//   ahbm_*                        AHB-Lite master signals
module ahbl_req_master #(
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [W_ADDR-1:0] req_addr,
    input  logic              req_write,
    input  logic [2:0]        req_size,
    input  logic [W_DATA-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [W_DATA-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              bus_fault,
    output logic [W_ADDR-1:0] ahbm_haddr,
    output logic              ahbm_hwrite,
    output logic [2:0]        ahbm_hsize,
    output logic [1:0]        ahbm_htrans,
    output logic [2:0]        ahbm_hburst,
    output logic [3:0]        ahbm_hprot,
    output logic              ahbm_hmastlock,
    output logic [W_DATA-1:0] ahbm_hwdata,
    input  logic              ahbm_hready,
    input  logic              ahbm_hresp,
    input  logic [W_DATA-1:0] ahbm_hrdata
);

    localparam int         W_CNT         = $clog2(TIMEOUT + 1);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    logic              aph_valid_q, aph_valid_d;
    logic [W_ADDR-1:0] aph_addr_q,  aph_addr_d;
    logic              aph_write_q, aph_write_d;
    logic [2:0]        aph_size_q,  aph_size_d;
    logic [W_DATA-1:0] aph_wdata_q, aph_wdata_d;
    logic              dph_valid_q, dph_valid_d;
    logic              dph_write_q, dph_write_d;
    logic [W_DATA-1:0] dph_wdata_q, dph_wdata_d;
    // A request that was dropped from APH still owes an error response.
    // It is issued only after the DPH transfer ahead of it has responded.
    logic              cxl_q,       cxl_d;
    logic [W_CNT-1:0]  wait_cnt_q,  wait_cnt_d;
    logic              bus_fault_q, bus_fault_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [W_DATA-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q,   rsp_err_d;

    logic err_first;
    logic timeout_hit;
    logic accept;
    logic req_legal;

    // The first cycle of a two-cycle ERROR response is detected here. A
    // timeout fires at the edge that would make this the TIMEOUT-th wait cycle.
    // No request is accepted while the slave signals an error or a timeout
    // is in progress, so that HTRANS is IDLE in the second error cycle.
    always_comb begin
        err_first   = dph_valid_q && !ahbm_hready && ahbm_hresp;
        timeout_hit = dph_valid_q && !ahbm_hready &&
                      (wait_cnt_q == W_CNT'(TIMEOUT - 1));
        req_ready   = !bus_fault_q && !timeout_hit &&
                      !(dph_valid_q && ahbm_hresp) &&
                      (!aph_valid_q || ahbm_hready);
        accept      = req_valid && req_ready;
        req_legal   = (req_size == 3'd0) ||
                      (req_size == 3'd1 && !req_addr[0]) ||
                      (req_size == 3'd2 && req_addr[1:0] == 2'b00);
    end

    // Pipeline advance, error cancellation, timeout and response generation.
    always_comb begin
        aph_valid_d = aph_valid_q;
        aph_addr_d  = aph_addr_q;
        aph_write_d = aph_write_q;
        aph_size_d  = aph_size_q;
        aph_wdata_d = aph_wdata_q;
        dph_valid_d = dph_valid_q;
        dph_write_d = dph_write_q;
        dph_wdata_d = dph_wdata_q;
        cxl_d       = cxl_q;
        bus_fault_d = bus_fault_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        if (ahbm_hready) begin
            dph_valid_d = aph_valid_q;
            dph_write_d = aph_write_q;
            dph_wdata_d = aph_wdata_q;
            aph_valid_d = 1'b0;
        end

        if (err_first || timeout_hit) begin
            if (aph_valid_q) begin
                cxl_d = 1'b1;
            end
            aph_valid_d = 1'b0;
        end

        if (timeout_hit) begin
            dph_valid_d = 1'b0;
            bus_fault_d = 1'b1;
        end

        if (accept) begin
            aph_valid_d = 1'b1;
            aph_addr_d  = req_addr;
            aph_write_d = req_write;
            aph_size_d  = req_size;
            aph_wdata_d = req_wdata;
        end

        if (dph_valid_q && !ahbm_hready && !timeout_hit) begin
            wait_cnt_d = wait_cnt_q + W_CNT'(1);
        end else begin
            wait_cnt_d = '0;
        end

        if (dph_valid_q && ahbm_hready) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = dph_write_q ? '0 : ahbm_hrdata;
            rsp_err_d   = ahbm_hresp;
        end else if (timeout_hit) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
        end else if (cxl_q && !dph_valid_q) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            cxl_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aph_valid_q <= 1'b0;
            aph_addr_q  <= '0;
            aph_write_q <= 1'b0;
            aph_size_q  <= 3'd0;
            aph_wdata_q <= '0;
            dph_valid_q <= 1'b0;
            dph_write_q <= 1'b0;
            dph_wdata_q <= '0;
            cxl_q       <= 1'b0;
            wait_cnt_q  <= '0;
            bus_fault_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            aph_valid_q <= aph_valid_d;
            aph_addr_q  <= aph_addr_d;
            aph_write_q <= aph_write_d;
            aph_size_q  <= aph_size_d;
            aph_wdata_q <= aph_wdata_d;
            dph_valid_q <= dph_valid_d;
            dph_write_q <= dph_write_d;
            dph_wdata_q <= dph_wdata_d;
            cxl_q       <= cxl_d;
            wait_cnt_q  <= wait_cnt_d;
            bus_fault_q <= bus_fault_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign ahbm_htrans    = aph_valid_q ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign ahbm_haddr     = aph_addr_q;
    assign ahbm_hwrite    = aph_write_q;
    assign ahbm_hsize     = aph_size_q;
    assign ahbm_hwdata    = (dph_valid_q && dph_write_q) ? dph_wdata_q : '0;
    assign ahbm_hburst    = 3'b000;
    assign ahbm_hprot     = 4'b0011;
    assign ahbm_hmastlock = 1'b0;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_err        = rsp_err_q;
    assign bus_fault      = bus_fault_q;

    // An accepted request must use HSIZE 0..2 and be aligned to that size.
    a_req_legal: assert property (@(posedge clk) disable iff (!rst_n)
        accept |-> req_legal);

endmodule

// File: tb/tb_ahbl_req_master.sv
// tb_ahbl_req_master
// Testbench for ahbl_req_master. It first runs directed scenarios: reset
// values, a single read, back-to-back writes, wait states, a two-cycle
// error, a timeout, and reset during a wait. It then runs randomized traffic
// against a memory slave. Responses in the random phase are compared with a
// transaction-level model, which is an in-order queue of requests plus a
// shadow memory.
module tb_ahbl_req_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = '0;
    logic        req_write = 1'b0;
    logic [2:0]  req_size = 3'd2;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        bus_fault;
    logic [31:0] ahbm_haddr;
    logic        ahbm_hwrite;
    logic [2:0]  ahbm_hsize;
    logic [1:0]  ahbm_htrans;
    logic [2:0]  ahbm_hburst;
    logic [3:0]  ahbm_hprot;
    logic        ahbm_hmastlock;
    logic [31:0] ahbm_hwdata;
    logic        ahbm_hready = 1'b1;
    logic        ahbm_hresp = 1'b0;
    logic [31:0] ahbm_hrdata = '0;

    ahbl_req_master #(.W_ADDR(32), .W_DATA(32), .TIMEOUT(255)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .bus_fault(bus_fault),
        .ahbm_haddr(ahbm_haddr), .ahbm_hwrite(ahbm_hwrite), .ahbm_hsize(ahbm_hsize),
        .ahbm_htrans(ahbm_htrans), .ahbm_hburst(ahbm_hburst), .ahbm_hprot(ahbm_hprot),
        .ahbm_hmastlock(ahbm_hmastlock), .ahbm_hwdata(ahbm_hwdata),
        .ahbm_hready(ahbm_hready), .ahbm_hresp(ahbm_hresp), .ahbm_hrdata(ahbm_hrdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic        w;
        logic [3:0]  idx;
        logic [31:0] d;
    } req_t;

    req_t        exp_q[$];
    req_t        e;
    logic [31:0] smem [16];
    logic [31:0] rmem [16];
    logic [31:0] exp_rd;
    logic [31:0] wd [4];
    logic        s_valid, s_w, pend, p_w, hr;
    logic [3:0]  s_idx, p_idx;
    logic [31:0] p_d, hd;
    int          s_wait, first_rsp, second_rsp, rsp_cnt;

    // All comparisons go through here; a mismatch prints one FAIL line.
    task automatic checkOutput(input string tag, input logic [63:0] obs,
                               input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge. Outputs are then sampled
    // 1ns later, which is well before the next rising edge.
    task automatic applyStimulus(input logic rv, input logic [31:0] ra,
                                 input logic rw, input logic [31:0] rwd,
                                 input logic h_rdy, input logic h_err,
                                 input logic [31:0] h_data);
        @(negedge clk);
        req_valid   = rv;
        req_addr    = ra;
        req_write   = rw;
        req_size    = 3'd2;
        req_wdata   = rwd;
        ahbm_hready = h_rdy;
        ahbm_hresp  = h_err;
        ahbm_hrdata = h_data;
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic assertReset();
        @(negedge clk);
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        ahbm_hready = 1'b1;
        ahbm_hresp  = 1'b0;
        #1;
    endtask

    task automatic releaseReset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_htrans"},    ahbm_htrans, 0);
        checkOutput({tag, "_haddr"},     ahbm_haddr, 0);
        checkOutput({tag, "_hwrite"},    ahbm_hwrite, 0);
        checkOutput({tag, "_hsize"},     ahbm_hsize, 0);
        checkOutput({tag, "_hwdata"},    ahbm_hwdata, 0);
        checkOutput({tag, "_rsp_valid"}, rsp_valid, 0);
        checkOutput({tag, "_rsp_rdata"}, rsp_rdata, 0);
        checkOutput({tag, "_rsp_err"},   rsp_err, 0);
        checkOutput({tag, "_bus_fault"}, bus_fault, 0);
        checkOutput({tag, "_req_ready"}, req_ready, 1);
        checkOutput({tag, "_hburst"},    ahbm_hburst, 0);
        checkOutput({tag, "_hprot"},     ahbm_hprot, 4'b0011);
        checkOutput({tag, "_hmastlock"}, ahbm_hmastlock, 0);
    endtask

    // Hard time limit, in case the design stalls the bench.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset values.
        assertReset();
        @(negedge clk);
        #1;
        checkResetValues("rst");
        releaseReset();

        // Single zero-wait read.
        applyStimulus(1'b1, 32'h10, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("rd_ready", req_ready, 1);
        idleCycle();
        checkOutput("rd_htrans", ahbm_htrans, 2'b10);
        checkOutput("rd_haddr", ahbm_haddr, 32'h10);
        checkOutput("rd_hwrite", ahbm_hwrite, 0);
        checkOutput("rd_hsize", ahbm_hsize, 2);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF);
        checkOutput("rd_htrans_idle", ahbm_htrans, 2'b00);
        checkOutput("rd_rsp_early", rsp_valid, 0);
        idleCycle();
        checkOutput("rd_rsp_valid", rsp_valid, 1);
        checkOutput("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        checkOutput("rd_rsp_err", rsp_err, 0);
        idleCycle();
        checkOutput("rd_rsp_pulse", rsp_valid, 0);

        // Four back-to-back writes.
        for (int k = 0; k < 4; k++) wd[k] = 32'hA000_0000 + 32'(k) * 32'h111;
        for (int c = 0; c < 8; c++) begin
            if (c < 4) applyStimulus(1'b1, 32'(c * 4), 1'b1, wd[c], 1'b1, 1'b0, 32'h0);
            else idleCycle();
            if (c < 4) checkOutput("wr4_ready", req_ready, 1);
            if (c >= 1 && c <= 4) begin
                checkOutput("wr4_htrans", ahbm_htrans, 2'b10);
                checkOutput("wr4_haddr", ahbm_haddr, 32'((c - 1) * 4));
            end else begin
                checkOutput("wr4_htrans_idle", ahbm_htrans, 2'b00);
            end
            if (c >= 2 && c <= 5) checkOutput("wr4_hwdata", ahbm_hwdata, wd[c - 2]);
            else checkOutput("wr4_hwdata_zero", ahbm_hwdata, 0);
            checkOutput("wr4_rsp_valid", rsp_valid, (c >= 3 && c <= 6) ? 1 : 0);
        end

        // Read with three wait states, write pipelined behind it.
        applyStimulus(1'b1, 32'h20, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h24, 1'b1, 32'h5555AAAA, 1'b1, 1'b0, 32'h0);
        checkOutput("ws_ready", req_ready, 1);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            checkOutput("ws_htrans_hold", ahbm_htrans, 2'b10);
            checkOutput("ws_haddr_hold", ahbm_haddr, 32'h24);
            checkOutput("ws_ready_low", req_ready, 0);
            checkOutput("ws_rsp_none", rsp_valid, 0);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h12345678);
        checkOutput("ws_rsp_none2", rsp_valid, 0);
        idleCycle();
        checkOutput("ws_rsp_valid", rsp_valid, 1);
        checkOutput("ws_rsp_rdata", rsp_rdata, 32'h12345678);
        checkOutput("ws_hwdata", ahbm_hwdata, 32'h5555AAAA);
        idleCycle();
        checkOutput("ws_rsp2_valid", rsp_valid, 1);
        checkOutput("ws_rsp2_rdata", rsp_rdata, 0);
        idleCycle();
        checkOutput("ws_rsp_done", rsp_valid, 0);

        // Two-cycle error on the first of two pipelined reads.
        applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h44, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("err_ready", req_ready, 1);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0);
        checkOutput("err1_htrans", ahbm_htrans, 2'b10);
        checkOutput("err1_ready", req_ready, 0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
        checkOutput("err2_htrans", ahbm_htrans, 2'b00);
        checkOutput("err2_rsp_none", rsp_valid, 0);
        idleCycle();
        checkOutput("err_rspA_valid", rsp_valid, 1);
        checkOutput("err_rspA_err", rsp_err, 1);
        idleCycle();
        checkOutput("err_rspB_valid", rsp_valid, 1);
        checkOutput("err_rspB_err", rsp_err, 1);
        idleCycle();
        checkOutput("err_rsp_done", rsp_valid, 0);
        checkOutput("err_htrans_idle", ahbm_htrans, 2'b00);

        // Timeout: slave never becomes ready.
        applyStimulus(1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h84, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        first_rsp = 0; second_rsp = 0; rsp_cnt = 0;
        for (int i = 1; i <= 300; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            if (rsp_valid) begin
                rsp_cnt++;
                if (first_rsp == 0) first_rsp = i;
                else if (second_rsp == 0) second_rsp = i;
                checkOutput("to_rsp_err", rsp_err, 1);
            end
        end
        checkOutput("to_first_rsp_cycle", 64'(first_rsp), 256);
        checkOutput("to_second_rsp_cycle", 64'(second_rsp), 257);
        checkOutput("to_rsp_count", 64'(rsp_cnt), 2);
        checkOutput("to_bus_fault", bus_fault, 1);
        checkOutput("to_ready", req_ready, 0);
        checkOutput("to_htrans", ahbm_htrans, 2'b00);
        applyStimulus(1'b1, 32'h88, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        checkOutput("to_ready_sticky", req_ready, 0);
        assertReset();
        checkResetValues("to_rst");
        releaseReset();
        idleCycle();
        checkOutput("to_rel_ready", req_ready, 1);
        checkOutput("to_rel_fault", bus_fault, 0);

        // Reset asserted during a wait state.
        applyStimulus(1'b1, 32'h90, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 32'h94, 1'b1, 32'hCAFE0000, 1'b1, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("rw_pre_haddr", ahbm_haddr, 32'h94);
        assertReset();
        checkResetValues("rw_rst");
        releaseReset();
        for (int c = 0; c < 4; c++) begin
            idleCycle();
            checkOutput("rw_no_rsp", rsp_valid, 0);
        end

        // Randomized traffic against a memory slave.
        assertReset();
        releaseReset();
        for (int i = 0; i < 16; i++) begin
            smem[i] = $urandom;
            rmem[i] = smem[i];
        end
        s_valid = 1'b0; s_w = 1'b0; s_idx = '0; s_wait = 0;
        pend = 1'b0; p_w = 1'b0; p_idx = '0; p_d = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc < 2800 && !pend && $urandom_range(0, 3) != 0) begin
                pend  = 1'b1;
                p_w   = 1'($urandom_range(0, 1));
                p_idx = 4'($urandom_range(0, 15));
                p_d   = $urandom;
            end
            hr = !(s_valid && s_wait > 0);
            hd = (s_valid && !s_w) ? smem[s_idx] : $urandom;
            applyStimulus(pend, 32'h100 + {26'h0, p_idx, 2'b00}, p_w, p_d, hr, 1'b0, hd);

            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    checkOutput("rnd_rsp_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.w) begin
                        rmem[e.idx] = e.d;
                        exp_rd = '0;
                    end else begin
                        exp_rd = rmem[e.idx];
                    end
                    checkOutput("rnd_rdata", rsp_rdata, exp_rd);
                    checkOutput("rnd_err", rsp_err, 0);
                end
            end
            checkOutput("rnd_htrans_legal",
                        (ahbm_htrans == 2'b00 || ahbm_htrans == 2'b10) ? 1 : 0, 1);
            if (!(s_valid && s_w)) checkOutput("rnd_hwdata_zero", ahbm_hwdata, 0);

            if (req_valid && req_ready) begin
                e.w = p_w; e.idx = p_idx; e.d = p_d;
                exp_q.push_back(e);
                pend = 1'b0;
            end
            if (s_valid && hr) begin
                if (s_w) smem[s_idx] = ahbm_hwdata;
                s_valid = 1'b0;
            end else if (s_valid) begin
                s_wait--;
            end
            if (hr && ahbm_htrans == 2'b10) begin
                s_valid = 1'b1;
                s_idx   = ahbm_haddr[5:2];
                s_w     = ahbm_hwrite;
                s_wait  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            end
            if (cyc >= 2800 && exp_q.size() == 0 && !s_valid && !pend) break;
        end
        checkOutput("rnd_drained", 64'(exp_q.size()), 0);
        checkOutput("rnd_bus_fault", bus_fault, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
